// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register state encoding and per-boundary payload widths.
`ifndef PIPE_XLEN
`define PIPE_XLEN 32
`endif
package pipe_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;
  localparam int XLEN     = `PIPE_XLEN;
  localparam int IF_ID_W  = 2 * XLEN;
  localparam int ID_EX_W  = 4 * XLEN + 16;
  localparam int EX_MEM_W = 3 * XLEN + 8;
  localparam int MEM_WB_W = 2 * XLEN + 8;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and optional two-entry skid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  logic in_x, out_x;
  assign in_x  = in_valid && in_ready;
  assign out_x = out_valid && out_ready;
  if (SKID != 0) begin : g_skid
    state_e           state_q;
    logic [WIDTH-1:0] main_q, skid_q;
    always_ff @(posedge sys_clk) begin
      if (sys_rst || flush) begin
        state_q <= EMPTY;
        main_q  <= RESET_DATA;
        skid_q  <= RESET_DATA;
      end else begin
        case (state_q)
          EMPTY: if (in_x) begin
            state_q <= BUSY;
            main_q  <= in_data;
          end
          BUSY: if (in_x && !out_x) begin
            state_q <= FULL;
            skid_q  <= in_data;
          end else if (in_x) begin
            main_q <= in_data;
          end else if (out_x) begin
            state_q <= EMPTY;
          end
          FULL: if (out_x) begin
            state_q <= BUSY;
            main_q  <= skid_q;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
    // ready is state-decoded; reset forces it high so upstream never sees a stall while in reset
    assign in_ready  = (state_q != FULL) || sys_rst;
    assign out_valid = state_q != EMPTY;
    assign occupancy = state_q;
    assign out_data  = main_q;
  end else begin : g_plain
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    always_ff @(posedge sys_clk) begin
      if (sys_rst || flush) begin
        valid_q <= 1'b0;
        main_q  <= RESET_DATA;
      end else if (in_x) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_x) begin
        valid_q <= 1'b0;
      end
    end
    assign in_ready  = !valid_q || out_ready || sys_rst;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};
    assign out_data  = main_q;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench driving a SKID=1 and a SKID=0 instance with shared stimulus.
module tb_pipe_stage_reg;
  localparam logic [31:0] RD = 32'h5A5A_0000;
  logic        clk = 1'b0;
  logic        sys_rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;
  logic [31:0] q1[$], q0[$];
  bit          clean1, clean0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_DATA(RD)) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1));
  pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_DATA(RD)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit ir1, ir0, ix1, ox1, ix0, ox0;
    @(negedge clk);
    sys_rst = 1'b0; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    ir1 = q1.size() < 2;
    ir0 = (q0.size() == 0) || ordy;
    chk("s1_in_ready", 32'(in_ready1), 32'(ir1));
    chk("s1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
    chk("s1_occupancy", 32'(occ1), 32'(q1.size()));
    if (q1.size() > 0) chk("s1_out_data", out_data1, q1[0]);
    else if (clean1) chk("s1_reset_data", out_data1, RD);
    chk("s0_in_ready", 32'(in_ready0), 32'(ir0));
    chk("s0_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
    chk("s0_occupancy", 32'(occ0), 32'(q0.size()));
    if (q0.size() > 0) chk("s0_out_data", out_data0, q0[0]);
    else if (clean0) chk("s0_reset_data", out_data0, RD);
    ox1 = q1.size() > 0 && ordy; ix1 = iv && ir1;
    ox0 = q0.size() > 0 && ordy; ix0 = iv && ir0;
    if (fl) begin
      q1.delete(); q0.delete(); clean1 = 1; clean0 = 1;
    end else begin
      if (ox1) void'(q1.pop_front());
      if (ix1) begin q1.push_back(d); clean1 = 0; end
      if (ox0) void'(q0.pop_front());
      if (ix0) begin q0.push_back(d); clean0 = 0; end
    end
  endtask

  task automatic rst_cycle(input logic iv, input logic [31:0] d);
    @(negedge clk);
    sys_rst = 1'b1; in_valid = iv; in_data = d; out_ready = 1'b0; flush = 1'b1;
    #1;
    chk("s1_in_ready_rst", 32'(in_ready1), 32'd1);
    chk("s0_in_ready_rst", 32'(in_ready0), 32'd1);
    q1.delete(); q0.delete(); clean1 = 1; clean0 = 1;
  endtask

  initial begin
    rst_cycle(1'b0, '0);
    rst_cycle(1'b1, 32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h12, 1'b1, 1'b0);
    step(1'b1, 32'h13, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0);
    rst_cycle(1'b1, 32'hE);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0));
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
